// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, digit patterns and
// the monitor state encoding. The display encoder uses the same constants.
package seg7_pkg;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // Active-high patterns with the decimal point off.
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern decoder (decimal point excluded).
// legal covers the ten digits and blank; anything else is illegal.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       legal,
   output logic       blank,
   output logic [3:0] digit
);

   always_comb begin
      legal = 1'b1;
      blank = 1'b0;
      digit = '0;
      case ({1'b0, pattern})
         SEG_BLANK: blank = 1'b1;
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_decode_monitor.sv
// Monitor for a 7-segment digit counter: decodes the sampled bus and flags
// illegal patterns, out-of-sequence steps and digits held for too long.
module seg7_decode_monitor
   import seg7_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       seg,
   output logic [3:0]       digit,
   output logic             digit_vld,
   output logic             dp,
   output logic             restart,
   output logic             pat_err,
   output logic             seq_err,
   output logic             stall_err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] good_cnt,
   output logic [1:0]       state
);

   localparam int unsigned          HOLD_W   = $clog2(HOLD_MAX + 2);
   localparam logic [HOLD_W-1:0]    HOLD_TOP = HOLD_W'(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0]    HOLD_ONE = HOLD_W'(1);
   localparam bit                   STALL_EN = (HOLD_MAX != 0);

   logic [7:0]        seg_q;
   logic [HOLD_W-1:0] hold_cnt, hold_n;
   state_t            cur_state, state_n;

   logic              dec_legal, dec_blank;
   logic [3:0]        dec_digit, succ_digit;

   logic [3:0]        digit_n;
   logic              vld_n, dp_n, restart_n, pat_n, seq_n, stall_n, sticky_n;
   logic [CNT_W-1:0]  good_n;

   seg7_to_bcd u_dec (
      .pattern (seg_q[6:0]),
      .legal   (dec_legal),
      .blank   (dec_blank),
      .digit   (dec_digit)
   );

   assign succ_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
   assign state      = cur_state;

   always_comb begin
      state_n   = cur_state;
      hold_n    = hold_cnt;
      digit_n   = digit;
      vld_n     = digit_vld;
      dp_n      = seg_q[SEG_DP];
      restart_n = 1'b0;
      pat_n     = 1'b0;
      seq_n     = 1'b0;
      stall_n   = 1'b0;
      good_n    = good_cnt;

      if (!dec_legal) begin
         pat_n   = 1'b1;
         vld_n   = 1'b0;
         hold_n  = '0;
         state_n = ST_IDLE;
      end else if (dec_blank) begin
         vld_n   = 1'b0;
         hold_n  = '0;
         state_n = ST_IDLE;
      end else if (cur_state == ST_IDLE) begin
         digit_n = dec_digit;
         vld_n   = 1'b1;
         hold_n  = HOLD_ONE;
         state_n = ST_TRACK;
      end else if (dec_digit == digit) begin
         if (hold_cnt != HOLD_TOP) hold_n = hold_cnt + 1'b1;
         // Zero is exempt: the source parks on 0 while it is held in reset.
         if (STALL_EN && cur_state == ST_TRACK && dec_digit != 4'd0 &&
             hold_n == HOLD_TOP) begin
            stall_n = 1'b1;
            state_n = ST_STALL;
         end
      end else begin
         digit_n = dec_digit;
         hold_n  = HOLD_ONE;
         state_n = ST_TRACK;
         if (dec_digit == succ_digit) begin
            if (good_cnt != '1) good_n = good_cnt + 1'b1;
         end else if (dec_digit == 4'd0) begin
            restart_n = 1'b1;
         end else begin
            seq_n = 1'b1;
         end
      end

      sticky_n = err_sticky | pat_n | seq_n | stall_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q      <= '0;
         hold_cnt   <= '0;
         cur_state  <= ST_IDLE;
         digit      <= '0;
         digit_vld  <= 1'b0;
         dp         <= 1'b0;
         restart    <= 1'b0;
         pat_err    <= 1'b0;
         seq_err    <= 1'b0;
         stall_err  <= 1'b0;
         err_sticky <= 1'b0;
         good_cnt   <= '0;
      end else begin
         seg_q      <= seg;
         hold_cnt   <= hold_n;
         cur_state  <= state_n;
         digit      <= digit_n;
         digit_vld  <= vld_n;
         dp         <= dp_n;
         restart    <= restart_n;
         pat_err    <= pat_n;
         seq_err    <= seq_n;
         stall_err  <= stall_n;
         err_sticky <= sticky_n;
         good_cnt   <= good_n;
      end
   end

endmodule

// File: tb/tb_seg7_decode_monitor.sv
// Bench for seg7_decode_monitor: directed scenarios plus random traffic,
// checked against a digit-level reference model of the monitor.
module tb_seg7_decode_monitor;

   localparam int TB_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] seg = 8'h00;
   logic [3:0] digit;
   logic       digit_vld, dp, restart, pat_err, seq_err, stall_err, err_sticky;
   logic [7:0] good_cnt;
   logic [1:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   seg7_decode_monitor #(.HOLD_MAX(TB_HOLD), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg        (seg),
      .digit      (digit),
      .digit_vld  (digit_vld),
      .dp         (dp),
      .restart    (restart),
      .pat_err    (pat_err),
      .seq_err    (seq_err),
      .stall_err  (stall_err),
      .err_sticky (err_sticky),
      .good_cnt   (good_cnt),
      .state      (state)
   );

   always #5 clk = ~clk;

   logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // Reference model: what the monitor should report about the displayed digits.
   int         m_digit, m_good, m_held;
   bit         m_vld, m_dp, m_restart, m_pat, m_seq, m_stall, m_sticky;
   bit         m_tracking, m_stalled;
   logic [7:0] m_segq;

   function automatic int decode(input logic [6:0] p);
      for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return i;
      if (p == 7'h00) return -1;
      return -2;
   endfunction

   task automatic model_reset();
      m_digit = 0; m_good = 0; m_held = 0;
      m_vld = 0; m_dp = 0; m_restart = 0; m_pat = 0; m_seq = 0; m_stall = 0;
      m_sticky = 0; m_tracking = 0; m_stalled = 0; m_segq = 8'h00;
   endtask

   task automatic model_eval(input logic [7:0] s);
      int d;
      d = decode(s[6:0]);
      m_restart = 0; m_pat = 0; m_seq = 0; m_stall = 0;
      m_dp = s[7];
      if (d == -2) begin
         m_pat = 1; m_vld = 0; m_tracking = 0; m_stalled = 0;
      end else if (d == -1) begin
         m_vld = 0; m_tracking = 0; m_stalled = 0;
      end else if (!m_tracking) begin
         m_digit = d; m_vld = 1; m_held = 1; m_tracking = 1; m_stalled = 0;
      end else if (d == m_digit) begin
         if (m_held < TB_HOLD + 1) m_held++;
         if (!m_stalled && TB_HOLD != 0 && d != 0 && m_held == TB_HOLD + 1) begin
            m_stall = 1; m_stalled = 1;
         end
      end else begin
         if (d == (m_digit + 1) % 10) begin
            if (m_good < 255) m_good++;
         end else if (d == 0) m_restart = 1;
         else m_seq = 1;
         m_digit = d; m_held = 1; m_stalled = 0;
      end
      if (m_pat || m_seq || m_stall) m_sticky = 1;
   endtask

   function automatic logic [20:0] exp_vec();
      logic [1:0] st;
      st = !m_tracking ? 2'd0 : (m_stalled ? 2'd2 : 2'd1);
      return {4'(m_digit), m_vld, m_dp, m_restart, m_pat, m_seq, m_stall,
              m_sticky, 8'(m_good), st};
   endfunction

   function automatic logic [20:0] dut_vec();
      return {digit, digit_vld, dp, restart, pat_err, seq_err, stall_err,
              err_sticky, good_cnt, state};
   endfunction

   // Drive one cycle and advance the model; sampling happens #1 after the edge.
   task automatic tick(input logic [7:0] s, input bit r);
      seg = s; rst = r;
      @(posedge clk); #1;
      if (r) model_reset();
      else begin
         model_eval(m_segq);
         m_segq = s;
      end
   endtask

   task automatic test_reset();
      logic [7:0] p;
      for (int i = 0; i < 3; i++) begin
         tick(8'h3F, 1);
         n_checks++;
         if (dut_vec() !== 21'h0) $display("FAIL reset_hold cyc %0d: got %h expected %h", i, dut_vec(), 21'h0);
         else n_pass++;
      end
      for (int i = 0; i < 2; i++) begin
         tick(8'h3F, 0);
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL reset_release cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      p = 8'h3F;
      n_checks++;
      if ({digit, digit_vld, state} !== {4'd0, 1'b1, 2'd1})
         $display("FAIL reset_first_load: got %h expected %h", {digit, digit_vld, state}, {4'd0, 1'b1, 2'd1});
      else n_pass++;
   endtask

   task automatic test_count();
      for (int i = 0; i <= 12; i++) begin
         tick({1'b0, pat_tab[(i < 11) ? (i % 10) : 0]}, 0);
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL count cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({good_cnt, err_sticky} !== {8'd10, 1'b0})
         $display("FAIL count_total: got %h expected %h", {good_cnt, err_sticky}, {8'd10, 1'b0});
      else n_pass++;
   endtask

   task automatic test_seq_err();
      logic [7:0] stim [5] = '{8'h4F, 8'h4F, 8'h6D, 8'h6D, 8'h6D};
      int pulses = 0;
      tick(8'h4F, 1);
      foreach (stim[i]) begin
         tick(stim[i], 0);
         pulses += int'(seq_err);
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL seq cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({pulses[3:0], err_sticky, digit, good_cnt} !== {4'd1, 1'b1, 4'd5, 8'd0})
         $display("FAIL seq_summary: got %h expected %h", {pulses[3:0], err_sticky, digit, good_cnt}, {4'd1, 1'b1, 4'd5, 8'd0});
      else n_pass++;
   endtask

   task automatic test_stall();
      logic [7:0] stim [9] = '{8'h4F, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h6D, 8'h6D};
      int pulses = 0;
      int stall_at = -1;
      tick(8'h4F, 1);
      foreach (stim[i]) begin
         tick(stim[i], 0);
         pulses += int'(stall_err);
         if (stall_err && stall_at < 0) stall_at = i;
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL stall cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      // Output of cycle 6 reflects the fifth consecutive sample of digit 4.
      n_checks++;
      if ({pulses[3:0], stall_at[3:0], state, good_cnt} !== {4'd1, 4'd6, 2'd1, 8'd2})
         $display("FAIL stall_summary: got %h expected %h", {pulses[3:0], stall_at[3:0], state, good_cnt}, {4'd1, 4'd6, 2'd1, 8'd2});
      else n_pass++;
   endtask

   task automatic test_pattern();
      logic [7:0] stim [5] = '{8'h5B, 8'h5B, 8'h55, 8'h4F, 8'h4F};
      int pats = 0;
      int seqs = 0;
      tick(8'h5B, 1);
      foreach (stim[i]) begin
         tick(stim[i], 0);
         pats += int'(pat_err);
         seqs += int'(seq_err);
         if (i == 3) begin
            n_checks++;
            if ({pat_err, digit_vld, state, digit} !== {1'b1, 1'b0, 2'd0, 4'd2})
               $display("FAIL pattern_illegal: got %h expected %h", {pat_err, digit_vld, state, digit}, {1'b1, 1'b0, 2'd0, 4'd2});
            else n_pass++;
         end
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL pattern cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({pats[3:0], seqs[3:0], digit, state} !== {4'd1, 4'd0, 4'd3, 2'd1})
         $display("FAIL pattern_summary: got %h expected %h", {pats[3:0], seqs[3:0], digit, state}, {4'd1, 4'd0, 4'd3, 2'd1});
      else n_pass++;
   endtask

   task automatic test_restart_reset();
      logic [7:0] stim [13] = '{8'h7D, 8'h3F, 8'h3F, 8'h55, 8'h3F, 8'h3F, 8'h06,
                                8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
      int rs = 0;
      int seqs = 0;
      tick(8'h7D, 1);
      foreach (stim[i]) begin
         tick(stim[i], 0);
         rs += int'(restart);
         seqs += int'(seq_err);
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL restart cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({rs[3:0], seqs[3:0], err_sticky} !== {4'd1, 4'd0, 1'b1})
         $display("FAIL restart_summary: got %h expected %h", {rs[3:0], seqs[3:0], err_sticky}, {4'd1, 4'd0, 1'b1});
      else n_pass++;
      tick(8'h7F, 1);
      n_checks++;
      if ({good_cnt, err_sticky, state, digit_vld} !== {8'd0, 1'b0, 2'd0, 1'b0})
         $display("FAIL midcount_reset: got %h expected %h", {good_cnt, err_sticky, state, digit_vld}, {8'd0, 1'b0, 2'd0, 1'b0});
      else n_pass++;
   endtask

   task automatic test_saturate();
      tick(8'h3F, 1);
      for (int i = 0; i < 280; i++) begin
         tick({1'b0, pat_tab[i % 10]}, 0);
         if (i % 40 == 0 || i > 255) begin
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL saturate cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
         end
      end
      n_checks++;
      if (good_cnt !== 8'hFF) $display("FAIL saturate_cap: got %h expected %h", good_cnt, 8'hFF);
      else n_pass++;
   endtask

   task automatic test_random();
      int sd = 0;
      int r;
      logic [7:0] s;
      tick(8'h00, 1);
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      begin sd = (sd + 1) % 10; s = {1'b0, pat_tab[sd]}; end
         else if (r < 70) s = {1'b0, pat_tab[sd]};
         else if (r < 80) begin sd = $urandom_range(0, 9); s = {1'b0, pat_tab[sd]}; end
         else if (r < 87) s = 8'h00;
         else begin
            s = 8'($urandom_range(0, 127));
            if (decode(s[6:0]) != -2) s = 8'h55;
         end
         s[7] = 1'($urandom_range(0, 1));
         tick(s, $urandom_range(0, 99) < 2);
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_count();
      test_seq_err();
      test_stall();
      test_pattern();
      test_restart_reset();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seg7_decode_monitor.md
Name: seg7_decode_monitor

Overview:
- Receiving end of the 7-segment bus driven by the 1 Hz digit counter (`seg[7:0]`).
- Samples the segment pattern and decodes it back to a BCD digit.
- Checks that the displayed sequence counts 0→9 with wrap and that no digit is held too long.
- Reports decode, sequence and stall errors.
- Sits beside the display driver as a self-checking monitor, in silicon or under a bench.

Parameters:
- HOLD_MAX, 4: max consecutive cycles a nonzero digit may stay unchanged before stall_err; 0 disables the stall check.
- CNT_W, 8: width of the good-step counter.

Ports:
- clk  in  1  system clock (1 Hz in the display system)
- rst  in  1  synchronous, active-high reset
- seg  in  8  segment bus, active-high; seg[0]=a … seg[6]=g, seg[7]=dp
- digit  out  4  last decoded digit 0-9
- digit_vld  out  1  digit holds a legal decoded value
- dp  out  1  registered decimal point
- restart  out  1  one-cycle pulse: digit returned to 0 from a digit other than 9
- pat_err  out  1  one-cycle pulse: illegal segment pattern
- seq_err  out  1  one-cycle pulse: change other than +1 mod 10 or restart
- stall_err  out  1  one-cycle pulse: nonzero digit held longer than HOLD_MAX
- err_sticky  out  1  OR of all error pulses since reset
- good_cnt  out  CNT_W  count of correct +1 steps, saturating
- state  out  2  FSM state: 0 IDLE, 1 TRACK, 2 STALL

Behaviour:
- Reset, synchronous, active-high, at posedge clk when rst=1:
  - all outputs 0, state IDLE
  - seg_q, last digit and hold counter cleared
  - reset mid-operation discards all history
- Pipeline: seg sampled into seg_q at edge k; decode, compare and all outputs registered at edge k+1. Latency 2 edges from seg change to outputs.
- Decode of seg_q[6:0], dp ignored:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9
  - 0x00 = blank
  - all other patterns illegal
- dp output follows seg_q[7] regardless of decode result.
- Illegal pattern:
  - pat_err pulses every cycle the pattern is present
  - digit_vld=0, digit keeps its old value
  - state→IDLE; no seq_err on the next legal digit
- Blank: digit_vld=0, state→IDLE, no error.
- IDLE: first legal digit is loaded (digit_vld=1, hold cnt=1), →TRACK, no sequence check.
- TRACK, same digit: hold cnt++, saturating at HOLD_MAX+1.
  - If HOLD_MAX≠0 and digit≠0 and hold cnt reaches HOLD_MAX+1: stall_err pulses once, →STALL.
  - Digit 0 is exempt, since it is the held value during source reset.
- TRACK/STALL, new digit d, old digit p, hold cnt reset to 1, →TRACK:
  - d = (p+1) mod 10, including 9→0: good_cnt++, saturating at all-ones.
  - d = 0, p≠9: restart pulse, no error.
  - otherwise: seq_err pulse.
- STALL, same digit: no further stall_err pulses.
- Simultaneous events: at most one of pat_err/seq_err/stall_err per cycle. Priority pat_err > seq_err > stall_err; restart never coincides with seq_err.
- err_sticky set on any error pulse, cleared only by rst.

Decomposition:
- Shared package seg7_pkg:
  - segment constants SEG_0 … SEG_9 and SEG_BLANK
  - bit-index constants SEG_A … SEG_G, SEG_DP
  - state encodings ST_IDLE/ST_TRACK/ST_STALL
  - the same constants feed the display encoder
- One sub-module, seg7_to_bcd: purely combinational 7-bit pattern → {legal, blank, digit[3:0]}.
- FSM, hold counter and good_cnt stay in the top module.

Test Plan:
1. rst=1 for 3 cycles with seg=0x3F → all outputs 0, state=0; after release, digit=0, digit_vld=1, state=1 two edges later.
2. Drive 0x3F,0x06,0x5B,…,0x6F,0x3F, one per cycle → digit 0..9..0, good_cnt=10, no error pulses, err_sticky=0.
3. Sequence 3 (0x4F) then 5 (0x6D) → seq_err one pulse, err_sticky=1, digit=5, good_cnt unchanged.
4. Hold 0x66 (digit 4) for 6 cycles, HOLD_MAX=4 → stall_err single pulse on 5th-held-cycle output, state=2; then 0x6D → state=1, good_cnt++.
5. Inject 0x55 between 2 and 3 → pat_err pulse, digit_vld=0, state=0; following 0x4F loads 3 without seq_err.
6. Digit 6 then 0x3F → restart pulse, no seq_err; assert rst mid-count at digit 7 → good_cnt=0, err_sticky=0, state=0 next edge.
